// File: rtl/jtframe_ps2_tx_if.sv
// Request/response handshake between a command requester and the PS/2 host transmitter.
interface jtframe_ps2_tx_if;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_req,
        input  tx_busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_req,
        output tx_busy,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/jtframe_ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// odd-parity byte out on device clock falling edges and checks the device ack.
module jtframe_ps2_tx #(
    parameter int INHIBIT_CYC = 4800,
    parameter int TIMEOUT_CYC = 720000,
    parameter int FILTER      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk_in,
    input  logic              ps2_data_in,
    output logic              ps2_clk_oe,
    output logic              ps2_data_oe,
    jtframe_ps2_tx_if.slave   bus
);
    localparam int INH_W = $clog2(INHIBIT_CYC);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam int FLT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SHIFT, ACK, WAITIDLE, DONE, ERR
    } state_t;

    // Bit 0 is the clock pad, bit 1 the data pad; both idle high when released.
    logic [1:0] pad_in;
    logic [1:0] pad_sync;
    assign pad_in = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] sync_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_reg <= 2'b11;
                else     sync_reg <= {sync_reg[0], pad_in[gi]};
            end
            assign pad_sync[gi] = sync_reg[1];
        end
    endgenerate

    logic             clk_filt_reg;
    logic [FLT_W-1:0] flt_cnt_reg;
    logic             fe_reg;

    // A new clock level is accepted only after FILTER consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt_reg <= 1'b1;
            flt_cnt_reg  <= '0;
            fe_reg       <= 1'b0;
        end else begin
            fe_reg <= 1'b0;
            if (pad_sync[0] == clk_filt_reg) begin
                flt_cnt_reg <= '0;
            end else if (flt_cnt_reg == FLT_W'(FILTER - 1)) begin
                clk_filt_reg <= pad_sync[0];
                flt_cnt_reg  <= '0;
                fe_reg       <= clk_filt_reg;
            end else begin
                flt_cnt_reg <= flt_cnt_reg + 1'b1;
            end
        end
    end

    state_t           state_reg;
    logic [9:0]       sr_reg;
    logic [3:0]       bit_cnt_reg;
    logic [INH_W-1:0] inh_cnt_reg;
    logic [WD_W-1:0]  wd_cnt_reg;
    logic             clk_oe_reg;
    logic             data_oe_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic             wd_expired;

    assign wd_expired = (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            inh_cnt_reg <= '0;
            wd_cnt_reg  <= '0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    if (bus.tx_req) begin
                        sr_reg      <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        busy_reg    <= 1'b1;
                        clk_oe_reg  <= 1'b1;
                        inh_cnt_reg <= '0;
                        state_reg   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    inh_cnt_reg <= inh_cnt_reg + 1'b1;
                    // Start bit goes out on the final inhibit cycle.
                    if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 2)) data_oe_reg <= 1'b1;
                    if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 1)) begin
                        clk_oe_reg <= 1'b0;
                        wd_cnt_reg <= '0;
                        state_reg  <= RTS;
                    end
                end
                RTS, SHIFT, ACK, WAITIDLE: begin
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    if (wd_expired) begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        err_reg     <= 1'b1;
                        state_reg   <= ERR;
                    end else if (state_reg == RTS) begin
                        if (fe_reg) begin
                            data_oe_reg <= ~sr_reg[0];
                            sr_reg      <= {1'b1, sr_reg[9:1]};
                            bit_cnt_reg <= 4'd1;
                            state_reg   <= SHIFT;
                        end
                    end else if (state_reg == SHIFT) begin
                        if (fe_reg) begin
                            data_oe_reg <= ~sr_reg[0];
                            sr_reg      <= {1'b1, sr_reg[9:1]};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == 4'd9) state_reg <= ACK;
                        end
                    end else if (state_reg == ACK) begin
                        if (fe_reg) begin
                            if (!pad_sync[1]) begin
                                state_reg <= WAITIDLE;
                            end else begin
                                clk_oe_reg  <= 1'b0;
                                data_oe_reg <= 1'b0;
                                busy_reg    <= 1'b0;
                                err_reg     <= 1'b1;
                                state_reg   <= ERR;
                            end
                        end
                    end else begin
                        if (clk_filt_reg && pad_sync[1]) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: state_reg <= IDLE;
                ERR: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign bus.tx_busy = busy_reg;
    assign bus.tx_done = done_reg;
    assign bus.tx_err  = err_reg;
endmodule

// File: tb/tb_jtframe_ps2_tx.sv
// Bench for jtframe_ps2_tx: a PS/2 device model clocks frames out of the transmitter,
// a scoreboard holds the expected outcome of each request and a monitor checks it.
`timescale 1ns/1ps
module tb_jtframe_ps2_tx;
    localparam int INHIBIT_CYC = 20;
    localparam int TIMEOUT_CYC = 500;
    localparam int FILTER      = 4;
    localparam int HALF        = 10;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_GLITCH = 3;
    localparam int M_RST    = 4;

    typedef struct { logic [7:0] b; int mode; } exp_t;
    typedef struct { logic [7:0] b; logic par; logic stop; logic start; } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_dlow = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_in, ps2_data_in;

    jtframe_ps2_tx_if bus();

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = ~dev_dlow & ~ps2_data_oe;

    jtframe_ps2_tx #(
        .INHIBIT_CYC(INHIBIT_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FILTER(FILTER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int dev_mode = M_ACK;
    int rst_req_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic string mode_name(input int m);
        case (m)
            M_ACK:    return "ack";
            M_NOACK:  return "noack";
            M_SILENT: return "silent";
            M_GLITCH: return "glitch";
            default:  return "reset";
        endcase
    endfunction

    // Device model: waits for the host's request-to-send, then clocks the frame in.
    initial begin : device
        int mode;
        logic [9:0] bits;
        logic start;
        bit aborted;
        obs_t o;
        bits = '0;
        forever begin
            @(negedge clk);
            if (!ps2_clk_oe) continue;
            while (ps2_clk_oe) @(negedge clk);
            mode = dev_mode;
            if (mode == M_SILENT) continue;
            repeat (HALF) @(negedge clk);
            start = ps2_data_in;
            aborted = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                if (mode == M_RST && k == 6) begin
                    rst_req_cnt++;
                    aborted = 1'b1;
                    break;
                end
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                for (int h = 0; h < HALF; h++) begin
                    dev_clk = !(mode == M_GLITCH && h == 4 && (k == 3 || k == 8));
                    @(negedge clk);
                end
                dev_clk = 1'b1;
                bits[k-1] = ps2_data_in;
            end
            if (aborted) continue;
            o.b = bits[7:0];
            o.par = bits[8];
            o.stop = bits[9];
            o.start = start;
            obs_q.push_back(o);
            if (mode != M_NOACK) dev_dlow = 1'b1;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            dev_dlow = 1'b0;
        end
    end

    // Monitor: inhibit shape, pulse rules and scoreboard comparison on done/err.
    int inh_len = 0;
    int inh_doe = 0;
    int rts_cnt = 0;
    bit rts_active = 1'b0;
    bit prev_clk_oe = 1'b0;
    bit prev_pulse = 1'b0;
    bit prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        obs_t o;
        logic exp_par;
        if (rts_active) rts_cnt++;
        if (ps2_clk_oe) begin
            inh_len++;
            if (ps2_data_oe) inh_doe++;
        end else if (prev_clk_oe) begin
            check("inhibit_len", 32'(inh_len), INHIBIT_CYC);
            check("start_on_last_inhibit_cycle", 32'(inh_doe), 1);
            check("start_bit_at_rts", 32'(ps2_data_oe), 1);
            inh_len = 0;
            inh_doe = 0;
            rts_cnt = 0;
            rts_active = 1'b1;
        end
        prev_clk_oe = ps2_clk_oe;

        check("done_err_exclusive", 32'(bus.tx_done & bus.tx_err), 0);
        if (prev_pulse) check("pulse_one_cycle", 32'({bus.tx_done, bus.tx_err}), 0);

        if (bus.tx_done || bus.tx_err) begin
            check("busy_low_on_pulse", 32'(bus.tx_busy), 0);
            check("busy_before_pulse", 32'(prev_busy), 1);
            check("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
            check("pulse_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outcome_done_err", 32'({bus.tx_done, bus.tx_err}),
                      (e.mode == M_ACK || e.mode == M_GLITCH) ? 32'h2 : 32'h1);
                if (e.mode == M_SILENT) begin
                    check("timeout_cycles", 32'(rts_cnt), TIMEOUT_CYC);
                end else begin
                    check("frame_observed", 32'(obs_q.size() > 0), 1);
                    if (obs_q.size() > 0) begin
                        o = obs_q.pop_front();
                        exp_par = ($countones(e.b) % 2 == 0);
                        check("start_bit_line", 32'(o.start), 0);
                        check("byte_on_line", 32'(o.b), 32'(e.b));
                        check("parity_bit", 32'(o.par), 32'(exp_par));
                        check("stop_released", 32'(o.stop), 1);
                    end
                end
            end
            rts_active = 1'b0;
        end
        prev_pulse = bus.tx_done | bus.tx_err;
        prev_busy = bus.tx_busy;
    end

    task automatic send(input logic [7:0] b, input int mode);
        int budget;
        int base;
        exp_t e;
        repeat (30) @(negedge clk);
        $display("txn byte=%02h mode=%s", b, mode_name(mode));
        dev_mode = mode;
        if (mode != M_RST) begin
            e.b = b;
            e.mode = mode;
            exp_q.push_back(e);
        end
        base = rst_req_cnt;
        bus.tx_data = b;
        bus.tx_req = 1'b1;
        @(negedge clk);
        check("busy_on_accept", 32'(bus.tx_busy), 1);
        bus.tx_req = 1'b0;
        bus.tx_data = 8'($urandom);
        budget = 0;
        if (mode == M_RST) begin
            while (rst_req_cnt == base && budget < 2000) begin
                @(negedge clk);
                budget++;
            end
            check("reset_point_reached", 32'(rst_req_cnt != base), 1);
            rst = 1'b1;
            #1;
            check("rst_clk_oe", 32'(ps2_clk_oe), 0);
            check("rst_data_oe", 32'(ps2_data_oe), 0);
            check("rst_busy", 32'(bus.tx_busy), 0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
        end else begin
            while (budget < 2000) begin
                @(negedge clk);
                budget++;
                if (!bus.tx_busy) break;
                bus.tx_req = ($urandom_range(0, 7) == 0);
            end
            bus.tx_req = 1'b0;
            check("frame_end_in_time", 32'(bus.tx_busy), 0);
        end
    endtask

    initial begin
        int r;
        bus.tx_req = 1'b0;
        bus.tx_data = 8'h00;
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_clk_oe", 32'(ps2_clk_oe), 0);
        check("reset_data_oe", 32'(ps2_data_oe), 0);
        check("reset_busy", 32'(bus.tx_busy), 0);
        check("reset_done", 32'(bus.tx_done), 0);
        check("reset_err", 32'(bus.tx_err), 0);
        rst = 1'b0;

        send(8'hED, M_ACK);
        send(8'h00, M_ACK);
        send(8'h01, M_ACK);
        send(8'hFF, M_ACK);
        send(8'h5A, M_NOACK);
        send(8'($urandom), M_SILENT);
        send(8'hA5, M_RST);
        send(8'hF4, M_ACK);
        send(8'($urandom), M_GLITCH);
        for (int i = 0; i < 6; i++) begin
            r = int'($urandom_range(0, 2));
            send(8'($urandom), (r == 0) ? M_ACK : (r == 1) ? M_NOACK : M_GLITCH);
        end

        repeat (50) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end
endmodule
